sdrc_cmd_sched: RTL
===================

Name: sdrc_cmd_sched

Overview:
- SDRAM command scheduler: owns the SDRAM command bus (cs_n/ras_n/cas_n/we_n/ba/addr).
- Runs the power-up init sequence, then arbitrates between an internal auto-refresh timer and one read/write request port.
- Closed-page policy: every access is ACT, then RD/WR with auto-precharge.
- Sits between the controller request logic and the SDRAM pads; its command pins are what the whitebox bench monitors.

Parameters:
- INIT_WAIT, 100: NOP cycles after reset release before the first PRECHARGE.
- TRP, 2: cycles from PRE to the next command.
- TRFC, 7: cycles from REF to the next command.
- TMRD, 2: cycles from MRS to init_done.
- TRCD, 2: cycles from ACT to RD/WR.
- TRWP, 6: cycles from RD/WR (auto-precharge) to return to IDLE.
- REF_INTERVAL, 780: cycles between refresh requests.
- MODE_REG, 13'h033: value driven on sdr_addr during MRS.

Ports:
- sdram_clk, input, 1: clock; all logic on the rising edge.
- sdram_resetn, input, 1: asynchronous, active-low reset.
- req, input, 1: access request; held until req_ack.
- req_wr, input, 1: 1 = write, 0 = read; stable while req=1.
- req_ba, input, 2: bank address.
- req_row, input, 13: row address.
- req_col, input, 10: column address.
- req_ack, output, 1: one-cycle pulse in the cycle RD/WR is driven.
- init_done, output, 1: high once init completes; stays high until reset.
- ref_busy, output, 1: high from REF issue through its TRFC wait.
- sdr_cs_n, output, 1: SDRAM chip select.
- sdr_ras_n, output, 1: SDRAM row address strobe.
- sdr_cas_n, output, 1: SDRAM column address strobe.
- sdr_we_n, output, 1: SDRAM write enable.
- sdr_ba, output, 2: SDRAM bank address.
- sdr_addr, output, 13: SDRAM address.

Behaviour:
- One clock (sdram_clk); reset asynchronous active-low (sdram_resetn). All outputs are registered.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001, MRS 0000.
- Reset values: NOP on command pins; sdr_ba=0, sdr_addr=0; init_done=0, req_ack=0, ref_busy=0; state INIT_WAIT; all counters 0; ref_pending=0.
- Reset asserted mid-operation: outputs return to NOP immediately (asynchronously); the full init sequence reruns after release.
- Any cycle not issuing a command drives NOP; sdr_ba and sdr_addr keep their last value.
- Timing convention: cycle 0 is the first rising edge after release. A command "at cycle k" is visible on the pins after edge k.
- States: INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, RW, REF, WAIT. WAIT uses a shared down-counter plus a stored return state.
- Init sequence:
  - INIT_WAIT_CNT=INIT_WAIT NOP cycles.
  - PRE with addr[10]=1 (precharge all), then wait TRP.
  - REF, wait TRFC; REF, wait TRFC.
  - MRS with ba=0, addr=MODE_REG, wait TMRD; init_done rises, go to IDLE.
- Refresh timer:
  - Enabled from the cycle init_done rises; counts 0..REF_INTERVAL-1 and wraps.
  - On wrap, sets ref_pending.
  - ref_pending clears in the cycle REF is issued.
  - A wrap while already pending leaves it at 1; no stacking.
- IDLE arbitration:
  - ref_pending has priority over req. Issue REF, ref_busy=1 for TRFC cycles, back to IDLE.
  - Else if req=1: ACT with ba=req_ba, addr=req_row.
  - After TRCD: READ/WRITE per req_wr, with ba=req_ba and addr={2'b00,1'b1,req_col}. req_ack=1 for that single cycle.
  - Then wait TRWP and return to IDLE.
- ACT-to-RW spacing is exactly TRCD cycles. Back-to-back requests: next ACT comes no earlier than TRWP cycles after RD/WR.
- A ref_pending raised during an access is served at the next IDLE, before any queued req.
- req while init_done=0: ignored (no ack) until init completes.
- req deasserted before ack is a protocol violation; behaviour is undefined and the bench must not exercise it.

Test Plan:
- Init, default params: release reset → NOP cycles 0–99; PRE (addr[10]=1) at 100; REF at 102 and 109; MRS addr=13'h033 at 116; init_done=1 at 118.
- Single read: req=1, req_wr=0, ba=2, row=13'h1ABC, col=10'h155 in IDLE at cycle T → ACT ba=2 addr=13'h1ABC at T; READ ba=2 addr=13'h0555 at T+2; req_ack high only at T+2; IDLE at T+8.
- Write back-to-back: req held with req_wr=1 for two transactions → two WRITE commands with auto-precharge; second ACT exactly 6 cycles after first WRITE; two req_ack pulses.
- Refresh vs request collision: ref_pending and req in the same IDLE cycle → REF first, ref_busy high 7 cycles, ACT 7 cycles after REF, then normal access.
- Refresh periodicity: idle bus after init → REF every 780 cycles, first at init_done+780 (± one IDLE-entry cycle); no other commands.
- Reset mid-access: assert sdram_resetn=0 in the cycle between ACT and READ → pins NOP asynchronously, init_done=0; after release, PRE again at cycle 100.

Source files
------------

// File: rtl/sdrc_cmd_sched.sv
// SDRAM command scheduler: power-up init, periodic auto-refresh and a single
// closed-page read/write port (ACT then RD/WR with auto-precharge).
module sdrc_cmd_sched #(
  parameter int          INIT_WAIT    = 100,
  parameter int          TRP          = 2,
  parameter int          TRFC         = 7,
  parameter int          TMRD         = 2,
  parameter int          TRCD         = 2,
  parameter int          TRWP         = 6,
  parameter int          REF_INTERVAL = 780,
  parameter logic [12:0] MODE_REG     = 13'h033
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic        req,
  input  logic        req_wr,
  input  logic [1:0]  req_ba,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  output logic        req_ack,
  output logic        init_done,
  output logic        ref_busy,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [1:0]  sdr_ba,
  output logic [12:0] sdr_addr
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  // The wait counter is loaded with T-2: one edge leaves WAIT, the next issues.
  localparam logic [15:0] INIT_LAST = 16'(INIT_WAIT - 1);
  localparam logic [15:0] TRP_LD    = 16'(TRP - 2);
  localparam logic [15:0] TRFC_LD   = 16'(TRFC - 2);
  localparam logic [15:0] TMRD_LD   = 16'(TMRD - 2);
  localparam logic [15:0] TRCD_LD   = 16'(TRCD - 2);
  localparam logic [15:0] TRWP_LD   = 16'(TRWP - 2);
  localparam logic [15:0] REF_LAST  = 16'(REF_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_RW, S_WAIT
  } state_t;

  state_t      state_r;
  state_t      ret_r;
  logic [15:0] cnt_r;
  logic [15:0] ref_cnt_r;
  logic        ref_pending_r;
  logic        init_done_r;
  logic        req_ack_r;
  logic        ref_busy_r;
  logic [3:0]  cmd_r;
  logic [1:0]  ba_r;
  logic [12:0] addr_r;
  logic        ref_issue_s;
  logic        timer_en_s;

  assign ref_issue_s = (state_r == S_IDLE) && init_done_r && ref_pending_r;
  // The timer starts on the same edge that raises init_done.
  assign timer_en_s  = init_done_r || (state_r == S_IDLE);

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_r;
  assign sdr_ba    = ba_r;
  assign sdr_addr  = addr_r;
  assign req_ack   = req_ack_r;
  assign init_done = init_done_r;
  assign ref_busy  = ref_busy_r;

  // Refresh interval timer and the single-deep pending flag.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      ref_cnt_r     <= 16'd0;
      ref_pending_r <= 1'b0;
    end else if (timer_en_s) begin
      if (ref_cnt_r == REF_LAST) begin
        ref_cnt_r     <= 16'd0;
        ref_pending_r <= 1'b1;
      end else begin
        ref_cnt_r <= ref_cnt_r + 16'd1;
        if (ref_issue_s) begin
          ref_pending_r <= 1'b0;
        end
      end
    end
  end

  // Command FSM: every command pin and status output is registered here.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_r     <= S_INIT_WAIT;
      ret_r       <= S_INIT_WAIT;
      cnt_r       <= 16'd0;
      init_done_r <= 1'b0;
      req_ack_r   <= 1'b0;
      ref_busy_r  <= 1'b0;
      cmd_r       <= CMD_NOP;
      ba_r        <= 2'd0;
      addr_r      <= 13'd0;
    end else begin
      cmd_r     <= CMD_NOP;
      req_ack_r <= 1'b0;
      case (state_r)
        S_INIT_WAIT: begin
          if (cnt_r == INIT_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= S_INIT_PRE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_INIT_PRE: begin
          cmd_r   <= CMD_PRE;
          addr_r  <= 13'h0400;
          cnt_r   <= TRP_LD;
          ret_r   <= S_INIT_REF1;
          state_r <= S_WAIT;
        end
        S_INIT_REF1: begin
          cmd_r   <= CMD_REF;
          cnt_r   <= TRFC_LD;
          ret_r   <= S_INIT_REF2;
          state_r <= S_WAIT;
        end
        S_INIT_REF2: begin
          cmd_r   <= CMD_REF;
          cnt_r   <= TRFC_LD;
          ret_r   <= S_INIT_MRS;
          state_r <= S_WAIT;
        end
        S_INIT_MRS: begin
          cmd_r   <= CMD_MRS;
          ba_r    <= 2'd0;
          addr_r  <= MODE_REG;
          cnt_r   <= TMRD_LD;
          ret_r   <= S_IDLE;
          state_r <= S_WAIT;
        end
        S_IDLE: begin
          init_done_r <= 1'b1;
          ref_busy_r  <= 1'b0;
          // Requests are only considered once init_done is already visible.
          if (init_done_r) begin
            if (ref_pending_r) begin
              cmd_r      <= CMD_REF;
              ref_busy_r <= 1'b1;
              cnt_r      <= TRFC_LD;
              ret_r      <= S_IDLE;
              state_r    <= S_WAIT;
            end else if (req) begin
              cmd_r   <= CMD_ACT;
              ba_r    <= req_ba;
              addr_r  <= req_row;
              cnt_r   <= TRCD_LD;
              ret_r   <= S_RW;
              state_r <= S_WAIT;
            end
          end
        end
        S_RW: begin
          cmd_r     <= req_wr ? CMD_WRITE : CMD_READ;
          ba_r      <= req_ba;
          addr_r    <= {2'b00, 1'b1, req_col};
          req_ack_r <= 1'b1;
          cnt_r     <= TRWP_LD;
          ret_r     <= S_IDLE;
          state_r   <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_r == 16'd0) begin
            state_r <= ret_r;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= S_INIT_WAIT;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

endmodule
